xil_bram_tdp_1clk_ctl: RTL and testbench



---
 rtl/xil_bram_tdp_1clk_ctl.sv | 190 +++++++++++++++++++
 tb/tb_xil_bram_tdp_1clk_ctl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xil_bram_tdp_1clk_ctl.sv
// Single-clock true-dual-port RAM for any depth: byte-lane writes, pipelined reads with a
// valid strobe, defined cross-port collisions and a sweep engine that fills the array with INIT_VAL.
module xil_bram_tdp_1clk_ctl #(
    parameter int unsigned    ADR        = 10,
    parameter int unsigned    DAT        = 18,
    parameter int unsigned    BEW        = 9,
    parameter int unsigned    DEP        = 1000,
    parameter int unsigned    DEL        = 2,
    parameter logic [DAT-1:0] INIT_VAL   = '0,
    parameter bit             CLR_ON_RST = 1'b1,
    parameter bit             COLL_FWD   = 1'b1,
    localparam int unsigned   NBE        = DAT / BEW
) (
    input  logic           clka_i,
    input  logic           rsta_i,
    input  logic           clr_req_i,
    output logic           busy_o,
    output logic           adr_err_o,
    input  logic [ADR-1:0] adra_i,
    input  logic [NBE-1:0] wena_i,
    input  logic [DAT-1:0] wdaa_i,
    input  logic           rena_i,
    output logic [DAT-1:0] rdaa_o,
    output logic           rvla_o,
    input  logic [ADR-1:0] adrb_i,
    input  logic [NBE-1:0] wenb_i,
    input  logic [DAT-1:0] wdab_i,
    input  logic           renb_i,
    output logic [DAT-1:0] rdab_o,
    output logic           rvlb_o
);

    typedef enum logic {StIdle, StClr} state_e;

    state_e         state_q;
    logic           busy_q;
    logic [ADR-1:0] cnt_q;
    logic           adr_err_q;
    logic           adr_err_d;

    logic [DAT-1:0] mem_q [DEP];

    logic           acc_en;
    logic           a_in, b_in;
    logic           same_adr;
    logic [NBE-1:0] a_we, b_we;
    logic           a_rd, b_rd;
    logic [DAT-1:0] a_rdat, b_rdat;

    logic [DEL-1:0] vla_q, vlb_q;
    logic [DAT-1:0] pda_q [DEL];
    logic [DAT-1:0] pdb_q [DEL];

    // Lane merge with port A taking priority over port B on shared lanes.
    function automatic logic [DAT-1:0] merge(input logic [DAT-1:0] old,
                                             input logic [NBE-1:0] wa,
                                             input logic [DAT-1:0] da,
                                             input logic [NBE-1:0] wb,
                                             input logic [DAT-1:0] db);
        logic [DAT-1:0] r;
        r = old;
        for (int i = 0; i < NBE; i++) begin
            if (wa[i]) begin
                r[i*BEW +: BEW] = da[i*BEW +: BEW];
            end else if (wb[i]) begin
                r[i*BEW +: BEW] = db[i*BEW +: BEW];
            end
        end
        return r;
    endfunction

    assign acc_en   = !busy_q;
    assign a_in     = adra_i <= ADR'(DEP - 1);
    assign b_in     = adrb_i <= ADR'(DEP - 1);
    assign same_adr = adra_i == adrb_i;
    assign a_we     = (acc_en && a_in) ? wena_i : '0;
    assign b_we     = (acc_en && b_in) ? wenb_i : '0;
    assign a_rd     = acc_en && rena_i;
    assign b_rd     = acc_en && renb_i;

    // A reader always sees its own port's write; the other port's only when forwarding.
    always_comb begin
        a_rdat = '0;
        b_rdat = '0;
        if (a_in) begin
            a_rdat = merge(mem_q[adra_i], a_we, wdaa_i,
                           (COLL_FWD && same_adr) ? b_we : '0, wdab_i);
        end
        if (b_in) begin
            b_rdat = merge(mem_q[adrb_i], (COLL_FWD && same_adr) ? a_we : '0, wdaa_i,
                           b_we, wdab_i);
        end
    end

    always_comb begin
        adr_err_d = adr_err_q;
        if (clr_req_i) begin
            adr_err_d = 1'b0;
        end else if (acc_en && ((((rena_i || (|wena_i)) && !a_in)) ||
                                 ((renb_i || (|wenb_i)) && !b_in))) begin
            adr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clka_i or posedge rsta_i) begin
        if (rsta_i) begin
            state_q   <= CLR_ON_RST ? StClr : StIdle;
            busy_q    <= CLR_ON_RST;
            cnt_q     <= '0;
            adr_err_q <= 1'b0;
        end else begin
            adr_err_q <= adr_err_d;
            unique case (state_q)
                StIdle: begin
                    if (clr_req_i) begin
                        state_q <= StClr;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                StClr: begin
                    if (cnt_q == ADR'(DEP - 1)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + ADR'(1);
                    end
                end
            endcase
        end
    end

    // Port B lanes are written first so that port A overrides them on a shared address.
    always_ff @(posedge clka_i) begin
        if (state_q == StClr) begin
            mem_q[cnt_q] <= INIT_VAL;
        end else begin
            for (int i = 0; i < NBE; i++) begin
                if (b_we[i]) begin
                    mem_q[adrb_i][i*BEW +: BEW] <= wdab_i[i*BEW +: BEW];
                end
            end
            for (int i = 0; i < NBE; i++) begin
                if (a_we[i]) begin
                    mem_q[adra_i][i*BEW +: BEW] <= wdaa_i[i*BEW +: BEW];
                end
            end
        end
    end

    // Data stages only load behind a valid, so the last stage holds between reads.
    always_ff @(posedge clka_i or posedge rsta_i) begin
        if (rsta_i) begin
            vla_q <= '0;
            vlb_q <= '0;
            for (int k = 0; k < DEL; k++) begin
                pda_q[k] <= '0;
                pdb_q[k] <= '0;
            end
        end else begin
            vla_q[0] <= a_rd;
            vlb_q[0] <= b_rd;
            if (a_rd) begin
                pda_q[0] <= a_rdat;
            end
            if (b_rd) begin
                pdb_q[0] <= b_rdat;
            end
            for (int k = 1; k < DEL; k++) begin
                vla_q[k] <= vla_q[k-1];
                vlb_q[k] <= vlb_q[k-1];
                if (vla_q[k-1]) begin
                    pda_q[k] <= pda_q[k-1];
                end
                if (vlb_q[k-1]) begin
                    pdb_q[k] <= pdb_q[k-1];
                end
            end
        end
    end

    assign busy_o    = busy_q;
    assign adr_err_o = adr_err_q;
    assign rdaa_o    = pda_q[DEL-1];
    assign rvla_o    = vla_q[DEL-1];
    assign rdab_o    = pdb_q[DEL-1];
    assign rvlb_o    = vlb_q[DEL-1];

endmodule

// File: tb/tb_xil_bram_tdp_1clk_ctl.sv
// Bench for xil_bram_tdp_1clk_ctl: a forwarding DEL=2 instance and a non-forwarding DEL=3
// instance share stimulus and are scored against one array model.
module tb_xil_bram_tdp_1clk_ctl;

    localparam int unsigned DEP  = 1000;
    localparam logic [17:0] INIT = 18'h155;

    logic        clk = 1'b0;
    logic        rsta = 1'b1;
    logic        clr_req;
    logic [9:0]  adra, adrb;
    logic [1:0]  wena, wenb;
    logic [17:0] wdaa, wdab;
    logic        rena, renb;

    logic        bsy [2];
    logic        aerr [2];
    logic [17:0] rda [2];
    logic [17:0] rdb [2];
    logic        rva [2];
    logic        rvb [2];

    always #5 clk = ~clk;

    xil_bram_tdp_1clk_ctl #(.DEL(2), .INIT_VAL(18'h155), .COLL_FWD(1'b1)) u_dut_fwd (
        .clka_i(clk), .rsta_i(rsta), .clr_req_i(clr_req), .busy_o(bsy[0]),
        .adr_err_o(aerr[0]), .adra_i(adra), .wena_i(wena), .wdaa_i(wdaa), .rena_i(rena),
        .rdaa_o(rda[0]), .rvla_o(rva[0]), .adrb_i(adrb), .wenb_i(wenb), .wdab_i(wdab),
        .renb_i(renb), .rdab_o(rdb[0]), .rvlb_o(rvb[0])
    );

    xil_bram_tdp_1clk_ctl #(.DEL(3), .INIT_VAL(18'h155), .COLL_FWD(1'b0)) u_dut_old (
        .clka_i(clk), .rsta_i(rsta), .clr_req_i(clr_req), .busy_o(bsy[1]),
        .adr_err_o(aerr[1]), .adra_i(adra), .wena_i(wena), .wdaa_i(wdaa), .rena_i(rena),
        .rdaa_o(rda[1]), .rvla_o(rva[1]), .adrb_i(adrb), .wenb_i(wenb), .wdab_i(wdab),
        .renb_i(renb), .rdab_o(rdb[1]), .rvlb_o(rvb[1])
    );

    logic [17:0] mem_m [DEP];
    bit          m_busy;
    int          m_cnt;
    bit          m_err;
    int          cyc;
    bit          ev [2][2][8];
    logic [17:0] ed [2][2][8];
    logic [17:0] hold [2][2];
    int          n_chk;
    int          n_fail;

    function automatic int dl(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [17:0] lane_merge(input logic [17:0] old, input logic [1:0] wa,
                                               input logic [17:0] da, input logic [1:0] wb,
                                               input logic [17:0] db);
        logic [17:0] r;
        r = old;
        for (int l = 0; l < 2; l++) if (wb[l]) r[l*9 +: 9] = db[l*9 +: 9];
        for (int l = 0; l < 2; l++) if (wa[l]) r[l*9 +: 9] = da[l*9 +: 9];
        return r;
    endfunction

    task automatic set_idle();
        clr_req = 0; rena = 0; renb = 0; wena = 0; wenb = 0;
        adra = 0; adrb = 0; wdaa = 0; wdab = 0;
    endtask

    task automatic model_reset();
        m_busy = 1; m_cnt = 0; m_err = 0;
        for (int i = 0; i < 2; i++)
            for (int p = 0; p < 2; p++) begin
                hold[i][p] = 18'h0;
                for (int s = 0; s < 8; s++) ev[i][p][s] = 0;
            end
    endtask

    // Effect of the coming clock edge, from the inputs currently applied.
    task automatic model_edge();
        bit ia, ib, sa;
        logic [1:0] wa, wb;
        logic [17:0] oa, ob;
        ia = int'(adra) < DEP;
        ib = int'(adrb) < DEP;
        sa = (adra == adrb);
        wa = (!m_busy && ia) ? wena : 2'b00;
        wb = (!m_busy && ib) ? wenb : 2'b00;
        oa = ia ? mem_m[adra] : 18'h0;
        ob = ib ? mem_m[adrb] : 18'h0;
        for (int i = 0; i < 2; i++) begin
            bit fwd;
            int s;
            fwd = (i == 0);
            s = (cyc + dl(i)) % 8;
            if (!m_busy && rena) begin
                ev[i][0][s] = 1;
                ed[i][0][s] = ia ? lane_merge(oa, wa, wdaa, (fwd && sa) ? wb : 2'b00, wdab) : 0;
            end
            if (!m_busy && renb) begin
                ev[i][1][s] = 1;
                ed[i][1][s] = ib ? lane_merge(ob, (fwd && sa) ? wa : 2'b00, wdaa, wb, wdab) : 0;
            end
        end
        if (clr_req) m_err = 0;
        else if (!m_busy && ((((rena || wena != 0) && !ia)) || ((renb || wenb != 0) && !ib)))
            m_err = 1;
        if (m_busy) begin
            mem_m[m_cnt] = INIT;
            m_cnt++;
            if (m_cnt == int'(DEP)) begin
                m_busy = 0;
                m_cnt = 0;
            end
        end else begin
            if (ib) mem_m[adrb] = lane_merge(mem_m[adrb], 2'b00, wdaa, wb, wdab);
            if (ia) mem_m[adra] = lane_merge(mem_m[adra], wa, wdaa, 2'b00, wdab);
            if (clr_req) begin
                m_busy = 1;
                m_cnt = 0;
            end
        end
    endtask

    task automatic compare_all();
        int s;
        s = cyc % 8;
        for (int i = 0; i < 2; i++) begin
            if (ev[i][0][s]) hold[i][0] = ed[i][0][s];
            if (ev[i][1][s]) hold[i][1] = ed[i][1][s];
            chk($sformatf("busy%0d", i), bsy[i], m_busy);
            chk($sformatf("adr_err%0d", i), aerr[i], m_err);
            chk($sformatf("rvla%0d", i), rva[i], ev[i][0][s]);
            chk($sformatf("rdaa%0d", i), rda[i], hold[i][0]);
            chk($sformatf("rvlb%0d", i), rvb[i], ev[i][1][s]);
            chk($sformatf("rdab%0d", i), rdb[i], hold[i][1]);
            ev[i][0][s] = 0;
            ev[i][1][s] = 0;
        end
    endtask

    task automatic step();
        if (!rsta) model_edge();
        @(posedge clk);
        #1;
        cyc++;
        compare_all();
        set_idle();
    endtask

    // Counts the cycles busy stays high; optionally fires an (ignored) clr_req mid-sweep.
    task automatic sweep_len(input string tag, input int clr_at);
        int n;
        n = 0;
        while (bsy[0] === 1'b1 && n < 1100) begin
            n++;
            if (n == clr_at) clr_req = 1;
            step();
        end
        chk(tag, n, DEP);
    endtask

    function automatic logic [9:0] rnd_adr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0) return 10'(1000 + $urandom_range(0, 23));
        if (r == 1) return 10'd999;
        return 10'($urandom_range(0, 7));
    endfunction

    task automatic rnd_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            rena = 1'($urandom_range(0, 1));
            renb = 1'($urandom_range(0, 1));
            wena = 2'($urandom_range(0, 3));
            wenb = 2'($urandom_range(0, 3));
            wdaa = 18'($urandom);
            wdab = 18'($urandom);
            adra = rnd_adr();
            adrb = rnd_adr();
            clr_req = ($urandom_range(0, 799) == 0);
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [17:0] w11, w22, old3;
        int adrs [3];
        n_chk = 0; n_fail = 0; cyc = 0;
        set_idle();
        model_reset();
        step();
        step();
        rsta = 0;
        sweep_len("sweep_after_reset", 500);

        adrs = '{0, 500, 999};
        foreach (adrs[j]) begin
            rena = 1; adra = 10'(adrs[j]);
            step();
            step();
            chk("sweep_value", rda[0], INIT);
        end

        wena = 2'b11; adra = 10'd5; wdaa = 18'h3A5A5;
        step();
        rena = 1; adra = 10'd5;
        step();
        chk("lat_early", rva[0], 0);
        step();
        chk("lat_valid", rva[0], 1);
        chk("lat_data", rda[0], 18'h3A5A5);
        step();
        chk("lat_late", rva[0], 0);
        chk("lat_hold", rda[0], 18'h3A5A5);

        wena = 2'b11; adra = 10'd7; wdaa = 18'h0;
        step();
        wena = 2'b10; adra = 10'd7; wdaa = 18'h3FFFF;
        step();
        rena = 1; adra = 10'd7;
        step();
        step();
        chk("byte_en", rda[0], 18'h3FE00);

        w11 = 18'h11111; w22 = 18'h22222;
        wena = 2'b01; wdaa = w11; adra = 10'd3;
        wenb = 2'b11; wdab = w22; adrb = 10'd3;
        step();
        rena = 1; adra = 10'd3;
        step();
        step();
        chk("coll_ww", rda[0], {w22[17:9], w11[8:0]});
        old3 = {w22[17:9], w11[8:0]};
        wena = 2'b11; wdaa = 18'h0ABCD; adra = 10'd3;
        renb = 1; adrb = 10'd3;
        step();
        step();
        step();
        step();
        chk("coll_fwd", rdb[0], 18'h0ABCD);
        chk("coll_old", rdb[1], old3);

        rena = 1; adra = 10'd1000;
        step();
        chk("range_err", aerr[0], 1);
        step();
        chk("range_rvl", rva[0], 1);
        chk("range_rd", rda[0], 0);
        step();
        step();
        chk("range_sticky", aerr[0], 1);
        clr_req = 1;
        step();
        chk("clr_err", aerr[0], 0);
        chk("clr_busy", bsy[0], 1);
        sweep_len("sweep_after_clr", 0);

        rnd_cycles(2000);
        while (m_busy && cyc < 90000) step();

        clr_req = 1;
        step();
        for (int k = 0; k < 1100 && m_cnt < 400; k++) step();
        chk("abort_at", m_cnt, 400);
        rsta = 1;
        model_reset();
        step();
        step();
        rsta = 0;
        sweep_len("sweep_after_abort", 300);

        rnd_cycles(300);
        for (int k = 0; k < 4; k++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
